// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// The main register drives the downstream outputs directly; the skid register absorbs the
// one extra beat that arrives while the registered upstream ready is still high. A flush
// squashes everything held and presents a NOP, and a saturating counter tracks cycles in
// which the stage did not hand a beat downstream.
module pipe_stage_skid #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              ready_i,
    input  logic              hold_flag_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;

    // skid entry: second beat parked while the main entry is stalled
    logic [INST_W-1:0] skid_inst_p0;
    logic [ADDR_W-1:0] skid_addr_p0;

    // main entry: drives the downstream interface
    logic              vld_p1;
    logic [INST_W-1:0] main_inst_p1;
    logic [ADDR_W-1:0] main_addr_p1;

    logic              ready_r;
    logic [CNT_W-1:0]  bubble_cnt;

    logic              acc_in;
    logic              rdy_eff;
    logic              acc_out;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    // A control stall looks exactly like downstream back-pressure.
    assign rdy_eff = ready_i & ~hold_flag_i;
    assign acc_in  = valid_i & ready_r;
    assign acc_out = vld_p1 & rdy_eff;

    assign ready_o      = ready_r;
    assign valid_o      = vld_p1;
    assign inst_o       = main_inst_p1;
    assign inst_addr_o  = main_addr_p1;
    assign bubble_cnt_o = bubble_cnt;

    // Handshake FSM; every output-facing value is registered here, and an empty main
    // entry always carries NOP/zero so no stale payload leaks downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_EMPTY;
            ready_r      <= 1'b1;
            vld_p1       <= 1'b0;
            main_inst_p1 <= NOP_INST;
            main_addr_p1 <= '0;
            skid_inst_p0 <= NOP_INST;
            skid_addr_p0 <= '0;
        end else if (flush_i) begin
            // flush wins over any accept on this edge; a beat leaving now is already delivered
            state        <= ST_EMPTY;
            ready_r      <= 1'b1;
            vld_p1       <= 1'b0;
            main_inst_p1 <= NOP_INST;
            main_addr_p1 <= '0;
            skid_inst_p0 <= NOP_INST;
            skid_addr_p0 <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state        <= ST_ONE;
                        vld_p1       <= 1'b1;
                        main_inst_p1 <= inst_i;
                        main_addr_p1 <= inst_addr_i;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        main_inst_p1 <= inst_i;
                        main_addr_p1 <= inst_addr_i;
                    end else if (acc_in) begin
                        // ready was still high when the main entry stalled: park the beat
                        state        <= ST_TWO;
                        ready_r      <= 1'b0;
                        skid_inst_p0 <= inst_i;
                        skid_addr_p0 <= inst_addr_i;
                    end else if (acc_out) begin
                        state        <= ST_EMPTY;
                        vld_p1       <= 1'b0;
                        main_inst_p1 <= NOP_INST;
                        main_addr_p1 <= '0;
                    end
                end
                ST_TWO: begin
                    // ready_r is low here, so nothing new can arrive
                    if (acc_out) begin
                        state        <= ST_ONE;
                        ready_r      <= 1'b1;
                        main_inst_p1 <= skid_inst_p0;
                        main_addr_p1 <= skid_addr_p0;
                        skid_inst_p0 <= NOP_INST;
                        skid_addr_p0 <= '0;
                    end
                end
                default: begin
                    state        <= ST_EMPTY;
                    ready_r      <= 1'b1;
                    vld_p1       <= 1'b0;
                    main_inst_p1 <= NOP_INST;
                    main_addr_p1 <= '0;
                end
            endcase
        end
    end

    // Bubble counter: any cycle without a completed downstream transfer; survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!vld_p1 || !rdy_eff) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule
